// File: rtl/led_fader_pkg.sv
// Shared definitions for the LED crossfader: state encodings and a ceil-log2 helper.
package led_fader_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFade   = 2'd1,
        StBreath = 2'd2
    } state_e;

    // Bits needed to hold values 0..value-1 (never less than one bit).
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        while ((64'd1 << bits) < 64'(value)) begin
            bits = bits + 1;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Brightness-step prescaler: counts 0..P_CYC-1 and flags the terminal count for one cycle.
module tick_gen
    import led_fader_pkg::*;
#(
    parameter int unsigned P_CYC = 1000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = clogb2(P_CYC);
    localparam logic [W-1:0] LAST = W'(P_CYC - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/led_fader.sv
// PWM crossfader for an LED pattern; optional idle "breathing" when LED_FADER_BREATH_EN is defined.
module led_fader
    import led_fader_pkg::*;
#(
    parameter int unsigned P_OUT_BIT    = 4,
    parameter int unsigned P_PWM_BIT    = 8,
    parameter int unsigned P_STEP_CYC   = 1000,
    parameter int unsigned P_IDLE_TICKS = 512
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [P_OUT_BIT-1:0] sig_i,
    output logic [P_OUT_BIT-1:0] led,
    output logic                 busy
);

    localparam logic [P_PWM_BIT-1:0] MAX      = '1;
    localparam logic [P_PWM_BIT-1:0] LVL_ONE  = P_PWM_BIT'(1);
    localparam logic [P_PWM_BIT-1:0] LVL_LAST = MAX - LVL_ONE;

    logic [P_PWM_BIT-1:0] pwm_cnt;
    logic [P_PWM_BIT-1:0] lvl;
    logic [P_OUT_BIT-1:0] cur_q;
    logic [P_OUT_BIT-1:0] old_q;
    state_e               state;
    logic                 change;
    logic                 tick;

    assign change = (sig_i != cur_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + LVL_ONE;
        end
    end

    // A pattern change restarts the step phase so every fade is exactly MAX steps long.
    tick_gen #(
        .P_CYC (P_STEP_CYC)
    ) u_tick_gen (
        .clk    (clk),
        .resetn (resetn),
        .clr    (change),
        .tick   (tick)
    );

`ifdef LED_FADER_BREATH_EN
    localparam int unsigned IDLE_W = clogb2(P_IDLE_TICKS);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(P_IDLE_TICKS - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

    logic [IDLE_W-1:0] idle_cnt;
    logic              dir_down;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= StIdle;
            cur_q <= '0;
            old_q <= '0;
            lvl   <= MAX;
`ifdef LED_FADER_BREATH_EN
            idle_cnt <= '0;
            dir_down <= 1'b1;
`endif
        end else if (change) begin
            // Any in-flight fade is abandoned; only the last full pattern fades out.
            old_q <= cur_q;
            cur_q <= sig_i;
            lvl   <= '0;
            state <= StFade;
`ifdef LED_FADER_BREATH_EN
            idle_cnt <= '0;
            dir_down <= 1'b1;
`endif
        end else begin
            case (state)
                StFade: begin
                    if (tick) begin
                        if (lvl >= LVL_LAST) begin
                            lvl   <= MAX;
                            state <= StIdle;
                        end else begin
                            lvl <= lvl + LVL_ONE;
                        end
                    end
                end
                StIdle: begin
`ifdef LED_FADER_BREATH_EN
                    if (tick) begin
                        if (idle_cnt >= IDLE_LAST) begin
                            idle_cnt <= '0;
                            lvl      <= MAX;
                            dir_down <= 1'b1;
                            state    <= StBreath;
                        end else begin
                            idle_cnt <= idle_cnt + IDLE_ONE;
                        end
                    end
`endif
                end
`ifdef LED_FADER_BREATH_EN
                StBreath: begin
                    if (tick) begin
                        if (dir_down) begin
                            if (lvl != '0) begin
                                lvl <= lvl - LVL_ONE;
                            end
                            if (lvl <= LVL_ONE) begin
                                dir_down <= 1'b0;
                            end
                        end else begin
                            if (lvl != MAX) begin
                                lvl <= lvl + LVL_ONE;
                            end
                            if (lvl >= LVL_LAST) begin
                                dir_down <= 1'b1;
                            end
                        end
                    end
                end
`endif
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    // Outputs depend only on registers, so reset forces led/busy low immediately.
    always_comb begin
        led = cur_q;
        case (state)
            StFade: begin
                led = (cur_q & {P_OUT_BIT{pwm_cnt < lvl}})
                    | (old_q & {P_OUT_BIT{pwm_cnt < (MAX - lvl)}});
            end
            StBreath: begin
                led = cur_q & {P_OUT_BIT{pwm_cnt < lvl}};
            end
            default: begin
                led = cur_q;
            end
        endcase
    end

    assign busy = (state == StFade);

endmodule

// File: doc/led_fader.md
LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 Parameter P_OUT_BIT, default 4, SHALL set the LED pattern width.
REQ-002 Parameter P_PWM_BIT, default 8, SHALL set the PWM counter and level width; MAX = 2^P_PWM_BIT-1.
REQ-003 Parameter P_STEP_CYC, default 1000, SHALL set the clk cycles per brightness step (>=2).
REQ-004 Parameter P_IDLE_TICKS, default 512, SHALL set the steps of stable pattern before breathing starts (used only with LED_FADER_BREATH_EN).
REQ-005 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-006 Port resetn, input, 1, SHALL be the asynchronous, active-low reset.
REQ-007 Port sig_i, input, P_OUT_BIT, SHALL be the target LED pattern (one-hot from the counter/onehot chain; any value accepted).
REQ-008 Port led, output, P_OUT_BIT, SHALL be the PWM-modulated LED drive.
REQ-009 Port busy, output, 1, SHALL be high while a crossfade is in progress.

Function
REQ-010 The PWM counter SHALL free-run 0..MAX and wrap MAX->0 every cycle outside reset.
REQ-011 The step prescaler SHALL count 0..P_STEP_CYC-1; tick SHALL be high for one cycle at the terminal count, then wrap to 0.
REQ-012 Registers: cur_q (new pattern), old_q (fading pattern), lvl (0..MAX), state in {IDLE, FADE, BREATH}.
REQ-013 IDLE: led SHALL equal cur_q (full on, no PWM); busy=0.
REQ-014 In any state, sig_i != cur_q at edge N SHALL load old_q<=cur_q, cur_q<=sig_i, lvl<=0, prescaler<=0, state<=FADE; busy=1 from cycle N+1.
REQ-015 FADE: led SHALL be (cur_q & {pwm_cnt < lvl}) | (old_q & {pwm_cnt < MAX-lvl}), ORed per bit.
REQ-016 FADE: each tick SHALL increment lvl by 1; the tick with lvl==MAX-1 SHALL set lvl=MAX and state<=IDLE, so a fade lasts exactly MAX*P_STEP_CYC cycles.
REQ-017 sig_i changing mid-fade SHALL restart per REQ-014; the partially faded old_q SHALL be dropped immediately.
REQ-018 sig_i returning to the old pattern mid-fade SHALL be treated as a new change (no reverse fade).
REQ-019 sig_i == cur_q SHALL never start a fade; an all-zero pattern SHALL fade like any other pattern.
REQ-020 lvl SHALL never exceed MAX or go below 0 (no wrap).

Reset
REQ-021 On resetn low: state=IDLE, cur_q=0, old_q=0, lvl=MAX, pwm_cnt=0, prescaler=0, idle counter=0; led=0, busy=0 asynchronously.
REQ-022 Reset mid-fade or mid-breath SHALL abort immediately; after release the first sig_i != 0 SHALL start a fade from all-off.

Configuration
REQ-023 Macro LED_FADER_BREATH_EN defined: IDLE SHALL count ticks while sig_i==cur_q; at P_IDLE_TICKS ticks enter BREATH with lvl=MAX.
REQ-024 BREATH: led = cur_q & {pwm_cnt < lvl}; lvl SHALL ramp down 1 per tick to 0, then up to MAX, repeating (triangle); busy=0.
REQ-025 BREATH: a sig_i change SHALL start a fade per REQ-014 with old_q at its full ramp (MAX-lvl law).
REQ-026 Macro undefined: no BREATH state, no idle counter, design stays in IDLE indefinitely; ports identical.

Structure
REQ-027 Shared header led_pkg.vh SHALL hold the state encodings (IDLE=0, FADE=1, BREATH=2) and the clogb2 constant function.
REQ-028 Prescaler SHALL be sub-module tick_gen (parameter P_CYC, ports clk, resetn, clr, tick); the rest stays in led_fader.

Verification (P_OUT_BIT=4, P_PWM_BIT=3 (MAX=7), P_STEP_CYC=4, P_IDLE_TICKS=3)
REQ-029 Reset release, sig_i=4'b0001 -> busy=1 next cycle, on-duty of led[0] rises 0/8..7/8, busy=0 and led=4'b0001 steady after 28 cycles.
REQ-030 Stable 4'b0001, sig_i=4'b0010 -> led[0] duty falls 7/8..0/8 while led[1] rises 0/8..7/8; summed duty per bit = 7/8 each PWM period.
REQ-031 Mid-fade (lvl=3) sig_i=4'b0100 -> lvl=0, old_q=4'b0010, led[0] never high again, fade completes 28 cycles after the change.
REQ-032 resetn low during FADE -> led=0, busy=0 in the same cycle; after release sig_i=4'b1000 fades from all-off.
REQ-033 With LED_FADER_BREATH_EN, 4'b0001 held -> after 12 idle cycles led[0] duty ramps 7..0..7 repeatedly; sig_i=4'b0010 -> busy=1, normal fade; without macro led stays 4'b0001.
